// File: rtl/game_pkg.sv
// Shared codes for the quiz game: controller states, judgement codes, HP status
// codes and the sign-magnitude entry type with its equality helper.
package game_pkg;

  typedef enum logic [3:0] {
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_DRAW     = 4'b0110,
    ST_WRONG    = 4'b0111,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011
  } state_e;

  typedef enum logic [1:0] {
    JUDG_NONE = 2'b00,
    JUDG_GOOD = 2'b01,
    JUDG_OUCH = 2'b10,
    JUDG_DRAW = 2'b11
  } judg_e;

  localparam logic [1:0] HP_PLAY    = 2'b00;
  localparam logic [1:0] HP_OPP_OUT = 2'b01;
  localparam logic [1:0] HP_PLY_OUT = 2'b10;
  localparam logic [1:0] HP_INIT    = 2'd3;
  localparam logic [3:0] MAG_MAX    = 4'd9;

  typedef struct packed {
    logic       sign;
    logic [3:0] mag;
  } sm_t;

  // Zero compares equal regardless of its sign bit.
  function automatic logic sm_eq(sm_t x, sm_t y);
    return (x.mag == y.mag) && ((x.sign == y.sign) || (x.mag == 4'd0));
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ cycles while
// enabled; the divider restarts from zero whenever the enable drops.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != LAST)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/answer_judge.sv
// Answer entry, judgement and HP bookkeeping for one quiz round.
// Define OPPONENT_TIMER_EN to build in the per-round opponent countdown timer.
module answer_judge
  import game_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int LIMIT_SEC = 10
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] STATE,
  input  logic [2:0] SEL,
  input  logic       DEC,
  input  logic       CLR_IN,
  input  logic       SUBMIT,
  input  logic [4:0] ANS_A,
  input  logic [4:0] ANS_B,
  output logic [1:0] JUDG_OUT,
  output logic       WRONG_OUT,
  output logic [1:0] HP_OUT,
  output logic [9:0] ENTRY,
  output logic [3:0] REMAIN
);

  sm_t        a_q, a_d, b_q, b_d;
  judg_e      judg_q, judg_d;
  logic       wrong_q, wrong_d;
  logic [1:0] opp_hp_q, opp_hp_d, ply_hp_q, ply_hp_d;
  logic [1:0] hp_out_q, hp_out_d;
  logic       prev_ready_q;

  logic in_input, in_ready, active, match, good, expire, reload;

  assign in_input = (STATE == ST_INPUT);
  assign in_ready = (STATE == ST_READY);
  assign active   = in_input && (judg_q == JUDG_NONE);
  assign reload   = in_ready && (hp_out_q != HP_PLAY);
  assign match    = (sm_eq(a_q, sm_t'(ANS_A)) && sm_eq(b_q, sm_t'(ANS_B))) ||
                    (sm_eq(a_q, sm_t'(ANS_B)) && sm_eq(b_q, sm_t'(ANS_A)));
  assign good     = active && SUBMIT && match;

`ifdef OPPONENT_TIMER_EN
  logic [3:0] remain_q, remain_d;
  logic       tick, tmr_en;

  assign tmr_en = active && (remain_q != 4'd0);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .en_i  (tmr_en),
    .tick_o(tick)
  );

  assign expire = tick && (remain_q == 4'd1);

  always_comb begin
    remain_d = remain_q;
    if (in_ready)  remain_d = 4'(LIMIT_SEC);
    else if (tick) remain_d = remain_q - 4'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) remain_q <= 4'(LIMIT_SEC);
    else        remain_q <= remain_d;
  end

  assign REMAIN = remain_q;
`else
  localparam int unused_cfg = CLK_HZ + LIMIT_SEC;
  assign expire = 1'b0;
  assign REMAIN = 4'd0;
`endif

  function automatic logic [3:0] mag_step(logic [3:0] m);
    return (m >= MAG_MAX) ? 4'd0 : m + 4'd1;
  endfunction

  // A held judgement releases only once the controller has left INPUT.
  always_comb begin
    judg_d = judg_q;
    if (judg_q != JUDG_NONE) begin
      if (!in_input) judg_d = JUDG_NONE;
    end else if (active) begin
      if (good && expire) judg_d = JUDG_DRAW;
      else if (good)      judg_d = JUDG_GOOD;
      else if (expire)    judg_d = JUDG_OUCH;
    end
  end

  always_comb begin
    wrong_d  = active && SUBMIT && !match;
    opp_hp_d = opp_hp_q;
    ply_hp_d = ply_hp_q;
    if (reload) begin
      opp_hp_d = HP_INIT;
      ply_hp_d = HP_INIT;
    end else if (judg_q == JUDG_NONE) begin
      if ((judg_d == JUDG_GOOD) && (opp_hp_q != 2'd0)) opp_hp_d = opp_hp_q - 2'd1;
      if ((judg_d == JUDG_OUCH) && (ply_hp_q != 2'd0)) ply_hp_d = ply_hp_q - 2'd1;
    end
    if (opp_hp_d == 2'd0)      hp_out_d = HP_OPP_OUT;
    else if (ply_hp_d == 2'd0) hp_out_d = HP_PLY_OUT;
    else                       hp_out_d = HP_PLAY;
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (reload || ((STATE == ST_QUESTION) && prev_ready_q)) begin
      a_d = '0;
      b_d = '0;
    end else if (active) begin
      if (CLR_IN) begin
        a_d = '0;
        b_d = '0;
      end else if (DEC) begin
        case (SEL)
          3'd0:    a_d.sign = ~a_q.sign;
          3'd1:    a_d.mag  = mag_step(a_q.mag);
          3'd2:    b_d.sign = ~b_q.sign;
          3'd3:    b_d.mag  = mag_step(b_q.mag);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q          <= '0;
      b_q          <= '0;
      judg_q       <= JUDG_NONE;
      wrong_q      <= 1'b0;
      opp_hp_q     <= HP_INIT;
      ply_hp_q     <= HP_INIT;
      hp_out_q     <= HP_PLAY;
      prev_ready_q <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      judg_q       <= judg_d;
      wrong_q      <= wrong_d;
      opp_hp_q     <= opp_hp_d;
      ply_hp_q     <= ply_hp_d;
      hp_out_q     <= hp_out_d;
      prev_ready_q <= in_ready;
    end
  end

  assign JUDG_OUT  = judg_q;
  assign WRONG_OUT = wrong_q;
  assign HP_OUT    = hp_out_q;
  assign ENTRY     = {a_q, b_q};

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge: a slow-timer instance for entry/judgement
// rounds and a fast-timer instance (CLK_HZ=4, LIMIT_SEC=2) for countdown rounds.
module tb_answer_judge;

  localparam logic [3:0] READY = 4'b0010, QUESTION = 4'b0011, INPUT = 4'b0100;
  localparam logic [3:0] GOOD = 4'b1000, OUCH = 4'b1001, DRAW = 4'b0110;
`ifdef OPPONENT_TIMER_EN
  localparam logic [3:0] F_RST_REMAIN = 4'd15;
  localparam logic [3:0] T_RST_REMAIN = 4'd2;
`else
  localparam logic [3:0] F_RST_REMAIN = 4'd0;
  localparam logic [3:0] T_RST_REMAIN = 4'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state;
  logic [2:0] sel;
  logic       dec, clr, submit;
  logic [4:0] ans_a, ans_b;

  logic [1:0] f_judg, t_judg, f_hp, t_hp;
  logic       f_wrong, t_wrong;
  logic [9:0] f_entry, t_entry;
  logic [3:0] f_remain, t_remain;

  int n_cmp = 0;
  int n_bad = 0;
  string      tag_q[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  answer_judge #(.CLK_HZ(1000), .LIMIT_SEC(15)) dut_f (
    .CLK(clk), .RST_N(rst_n), .STATE(state), .SEL(sel), .DEC(dec), .CLR_IN(clr),
    .SUBMIT(submit), .ANS_A(ans_a), .ANS_B(ans_b), .JUDG_OUT(f_judg),
    .WRONG_OUT(f_wrong), .HP_OUT(f_hp), .ENTRY(f_entry), .REMAIN(f_remain)
  );

  answer_judge #(.CLK_HZ(4), .LIMIT_SEC(2)) dut_t (
    .CLK(clk), .RST_N(rst_n), .STATE(state), .SEL(sel), .DEC(dec), .CLR_IN(clr),
    .SUBMIT(submit), .ANS_A(ans_a), .ANS_B(ans_b), .JUDG_OUT(t_judg),
    .WRONG_OUT(t_wrong), .HP_OUT(t_hp), .ENTRY(t_entry), .REMAIN(t_remain)
  );

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_dec(logic [2:0] s, int n);
    sel = s;
    repeat (n) begin
      dec = 1'b1;
      step();
      dec = 1'b0;
    end
  endtask

  task automatic do_submit();
    submit = 1'b1;
    step();
    submit = 1'b0;
  endtask

  task automatic round_start();
    state = READY;
    step();
    state = QUESTION;
    step();
    state = INPUT;
  endtask

  task automatic expect_v(string tag, logic [15:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic compare_v(logic [15:0] obs);
    string       t;
    logic [15:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", t, obs, e);
    end
  endtask

  task automatic check_reset_outputs(string pfx);
    expect_v({pfx, " f_judg"}, 16'd0);                compare_v(16'(f_judg));
    expect_v({pfx, " f_wrong"}, 16'd0);               compare_v(16'(f_wrong));
    expect_v({pfx, " f_hp"}, 16'd0);                  compare_v(16'(f_hp));
    expect_v({pfx, " f_entry"}, 16'd0);               compare_v(16'(f_entry));
    expect_v({pfx, " f_remain"}, 16'(F_RST_REMAIN));  compare_v(16'(f_remain));
    expect_v({pfx, " t_remain"}, 16'(T_RST_REMAIN));  compare_v(16'(t_remain));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; state = READY; sel = 3'd0; dec = 1'b0; clr = 1'b0; submit = 1'b0;
    ans_a = 5'b00010; ans_b = 5'b10011;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Round 1: ANS (+2,-3), entry built to (+2,-3)
    round_start();
    pulse_dec(3'd1, 2);
    pulse_dec(3'd2, 1);
    pulse_dec(3'd3, 3);
    expect_v("r1 entry", 16'h053);  compare_v(16'(f_entry));
    expect_v("r1 judg good", 16'd1);
    do_submit();
    compare_v(16'(f_judg));
    expect_v("r1 hp play", 16'd0);  compare_v(16'(f_hp));
    expect_v("r1 edit locked", 16'h053);
    pulse_dec(3'd1, 1);
    compare_v(16'(f_entry));
    expect_v("r1 judg hold", 16'd1); compare_v(16'(f_judg));
    state = GOOD;
    expect_v("r1 judg release", 16'd0);
    step();
    compare_v(16'(f_judg));

    // Round 2: ANS (-3,+2), same entry in swapped order
    state = READY; ans_a = 5'b10011; ans_b = 5'b00010;
    step();
    state = QUESTION;
    expect_v("r2 new round clear", 16'd0);
    step();
    compare_v(16'(f_entry));
    state = INPUT;
    pulse_dec(3'd1, 2);
    pulse_dec(3'd2, 1);
    pulse_dec(3'd3, 3);
    expect_v("r2 judg swapped", 16'd1);
    do_submit();
    compare_v(16'(f_judg));
    state = GOOD;
    step();

    // Round 3: wrong entry (+2,+3), then clear/wrap, then (-3,+2)
    round_start();
    pulse_dec(3'd1, 2);
    pulse_dec(3'd3, 3);
    expect_v("r3 wrong pulse", 16'd1);
    expect_v("r3 wrong judg", 16'd0);
    do_submit();
    compare_v(16'(f_wrong));
    compare_v(16'(f_judg));
    expect_v("r3 wrong drop", 16'd0);
    expect_v("r3 entry kept", 16'h043);
    step();
    compare_v(16'(f_wrong));
    compare_v(16'(f_entry));
    clr = 1'b1;
    expect_v("r3 clr beats dec", 16'd0);
    pulse_dec(3'd1, 1);
    clr = 1'b0;
    compare_v(16'(f_entry));
    expect_v("r3 mag nine", 16'h120);
    pulse_dec(3'd1, 9);
    compare_v(16'(f_entry));
    expect_v("r3 mag wrap", 16'h000);
    pulse_dec(3'd1, 1);
    compare_v(16'(f_entry));
    pulse_dec(3'd0, 1);
    pulse_dec(3'd1, 3);
    pulse_dec(3'd3, 2);
    expect_v("r3 entry", 16'h262);  compare_v(16'(f_entry));
    expect_v("r3 judg good", 16'd1);
    expect_v("r3 hp opp out", 16'd1);
    do_submit();
    compare_v(16'(f_judg));
    compare_v(16'(f_hp));
    state = GOOD;
    step();
    state = READY;
    expect_v("reload hp", 16'd0);
    expect_v("reload clear", 16'd0);
    step();
    compare_v(16'(f_hp));
    compare_v(16'(f_entry));

    // Round 4: ANS (-0,+5), entry (+0,+5); edits ignored outside INPUT
    ans_a = 5'b10000; ans_b = 5'b00101;
    state = QUESTION;
    step();
    expect_v("r4 question locked", 16'd0);
    pulse_dec(3'd3, 1);
    compare_v(16'(f_entry));
    state = INPUT;
    pulse_dec(3'd3, 5);
    expect_v("r4 neg zero judg", 16'd1);
    do_submit();
    compare_v(16'(f_judg));

    // Asynchronous reset in the middle of a judged round
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async rst");
    rst_n = 1'b1;
    step();

`ifdef OPPONENT_TIMER_EN
    // Countdown: REMAIN 2,1,0 in 4-cycle steps, expiry judged as OUCH
    ans_a = 5'b00001; ans_b = 5'b00001;
    state = READY;
    step();
    expect_v("tmr reload", 16'd2);  compare_v(16'(t_remain));
    state = QUESTION;
    step();
    state = INPUT;
    step(3);
    expect_v("tmr before tick", 16'd2); compare_v(16'(t_remain));
    step();
    expect_v("tmr tick1", 16'd1);       compare_v(16'(t_remain));
    step(3);
    expect_v("tmr hold1", 16'd1);       compare_v(16'(t_remain));
    step();
    expect_v("tmr expire remain", 16'd0); compare_v(16'(t_remain));
    expect_v("tmr ouch", 16'd2);          compare_v(16'(t_judg));
    step(2);
    expect_v("tmr stay zero", 16'd0);   compare_v(16'(t_remain));
    expect_v("tmr ouch hold", 16'd2);   compare_v(16'(t_judg));
    expect_v("tmr hp after 1", 16'd0);  compare_v(16'(t_hp));
    for (int r = 0; r < 2; r++) begin
      state = OUCH;
      step();
      round_start();
      step(8);
      expect_v("tmr ouch round", 16'd2); compare_v(16'(t_judg));
    end
    expect_v("tmr ply out", 16'd2);     compare_v(16'(t_hp));

    // Correct submit on the expiry edge is a draw with no HP change
    state = OUCH;
    step();
    state = READY;
    step();
    expect_v("tmr reload hp", 16'd0);   compare_v(16'(t_hp));
    state = QUESTION;
    step();
    state = INPUT;
    pulse_dec(3'd1, 1);
    pulse_dec(3'd3, 1);
    step(5);
    expect_v("draw judg", 16'd3);
    expect_v("draw remain", 16'd0);
    do_submit();
    compare_v(16'(t_judg));
    compare_v(16'(t_remain));
    state = DRAW;
    step();
    for (int r = 0; r < 2; r++) begin
      round_start();
      step(8);
      state = OUCH;
      step();
    end
    expect_v("draw kept hp", 16'd0);    compare_v(16'(t_hp));
    round_start();
    step(8);
    expect_v("draw third ouch", 16'd2); compare_v(16'(t_hp));
`else
    // Without the timer nothing ever expires
    ans_a = 5'b00001; ans_b = 5'b00001;
    round_start();
    step(20);
    expect_v("notmr judg", 16'd0);      compare_v(16'(t_judg));
    expect_v("notmr remain", 16'd0);    compare_v(16'(t_remain));
    pulse_dec(3'd1, 1);
    pulse_dec(3'd3, 1);
    expect_v("notmr good", 16'd1);
    do_submit();
    compare_v(16'(t_judg));
    expect_v("notmr hp", 16'd0);        compare_v(16'(t_hp));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/answer_judge.md
ANSWER_JUDGE -- requirements
Module: answer_judge

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: clock cycles per one-second tick.
REQ-002 Parameter LIMIT_SEC, default 10: opponent time limit per round, in seconds (1..15).
REQ-003 CLK  in  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 STATE  in  4  registered game-controller state (READY=0010, QUESTION=0011, INPUT=0100, WRONG=0111, GOOD=1000, OUCH=1001, DRAW=0110, WIN=1010, LOSE=1011).
REQ-006 SEL  in  3  entry slot select: 0=sign a, 1=|a|, 2=sign b, 3=|b|; values 4..7 select nothing.
REQ-007 DEC  in  1  one-cycle pulse: step the selected slot.
REQ-008 CLR_IN  in  1  one-cycle pulse: clear all slots.
REQ-009 SUBMIT  in  1  one-cycle pulse: judge the current entry.
REQ-010 ANS_A, ANS_B  in  5 each  expected factors, sign-magnitude {sign, 4-bit magnitude 0..9}, stable while STATE is QUESTION or INPUT.
REQ-011 JUDG_OUT  out  2  registered judgement: 00 none, 01 good, 10 ouch, 11 draw.
REQ-012 WRONG_OUT  out  1  registered one-cycle pulse: incorrect submission.
REQ-013 HP_OUT  out  2  registered: 00 play on, 01 opponent HP exhausted, 10 player HP exhausted.
REQ-014 ENTRY  out  10  current {a, b} entry, sign-magnitude, for display.
REQ-015 REMAIN  out  4  seconds left in the round.

Function
REQ-016 Slot edits, submits and the timer SHALL act only while STATE==INPUT and JUDG_OUT==00.
REQ-017 DEC on a sign slot SHALL toggle it; on a magnitude slot it SHALL increment with wrap 9->0.
REQ-018 CLR_IN SHALL zero all slots; CLR_IN and DEC in the same cycle: CLR_IN wins.
REQ-019 SUBMIT SHALL compare the pre-edit entry in the same cycle; {a,b} matches {ANS_A,ANS_B} in either order; +0 and -0 SHALL be equal.
REQ-020 Match -> JUDG_OUT=01 on the next edge; mismatch -> WRONG_OUT=1 for exactly one cycle, entry kept.
REQ-021 Timer SHALL reload REMAIN=LIMIT_SEC while STATE==READY, decrement once per tick while counting, pause in all other states.
REQ-022 REMAIN reaching 0 -> JUDG_OUT=10; REMAIN SHALL stay at 0.
REQ-023 Correct SUBMIT in the same cycle as the 1->0 expiry SHALL give JUDG_OUT=11, not 01 or 10.
REQ-024 JUDG_OUT SHALL hold its nonzero value until STATE!=INPUT, then return to 00 on the next edge.
REQ-025 Player HP and opponent HP SHALL be 2-bit counters starting at 3; 01 decrements opponent HP, 10 decrements player HP, 11 neither; each decrement happens once, on the edge JUDG_OUT becomes nonzero.
REQ-026 HP_OUT SHALL be 01 if opponent HP==0, else 10 if player HP==0, else 00.
REQ-027 When STATE==READY and HP_OUT!=00, both HP counters SHALL reload to 3 and the slots SHALL clear.
REQ-028 Slots SHALL clear when STATE is QUESTION immediately after READY (new round).

Reset
REQ-029 RST_N low SHALL set: JUDG_OUT=00, WRONG_OUT=0, HP_OUT=00, ENTRY=0, REMAIN=LIMIT_SEC, both HP=3, tick divider=0, regardless of clock.
REQ-030 Reset mid-round SHALL discard any pending judgement; no HP change results from it.

Configuration
REQ-031 With OPPONENT_TIMER_EN defined, REQ-021..023 apply.
REQ-032 Without it: no timer or divider logic, REMAIN tied to 0, JUDG_OUT only 00 or 01, player HP never decrements.

Structure
REQ-033 Shared package game_pkg SHALL hold state codes, JUDG codes (NONE/GOOD/OUCH/DRAW), HP codes and HP_INIT=3.
REQ-034 One sub-module tick_gen (parameter CLK_HZ, enable input, one-cycle tick output, divider cleared when disabled) SHALL produce the 1 Hz tick.

Verification
REQ-035 ANS=(+2,-3); STATE=INPUT; DEC slot1 x2, DEC slot2, DEC slot3 x3; SUBMIT -> ENTRY=(+2,-3), JUDG_OUT=01 next edge, opponent HP 3->2.
REQ-036 ANS=(-3,+2), entry (+2,-3) SUBMIT -> JUDG_OUT=01 (order-free); entry (+2,+3) -> WRONG_OUT high exactly 1 cycle, JUDG_OUT=00.
REQ-037 CLK_HZ=4, LIMIT_SEC=2, INPUT held -> REMAIN 2,1,0 at 4-cycle steps; JUDG_OUT=10 at expiry; player HP 3->2.
REQ-038 Same setup, correct SUBMIT on expiry cycle -> JUDG_OUT=11, no HP change.
REQ-039 Three GOOD rounds -> HP_OUT=01; STATE=READY -> HP reload, HP_OUT=00 next edge.
REQ-040 RST_N low mid-INPUT with JUDG_OUT=01 -> all outputs at REQ-029 values immediately, before next CLK edge.
